// File: rtl/eth_rx_hdr_filter_if.sv
// 8-bit AXI-stream bundle without tready, as produced by the MII MAC receive path.
// master drives the byte stream, slave consumes it.
interface eth_rx_hdr_filter_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tlast;
   logic       tuser;

   modport master (output tdata, tvalid, tlast, tuser);
   modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/eth_rx_hdr_filter.sv
// Ethernet receive header parser and destination filter: publishes the 14-byte header,
// forwards payload of accepted frames with one cycle latency, drops the rest unbuffered.
module eth_rx_hdr_filter (
   input  logic                clk,
   input  logic                rst,
   eth_rx_hdr_filter_if.slave  s_axis,
   eth_rx_hdr_filter_if.master m_axis,
   output logic [47:0]         m_eth_dest_mac,
   output logic [47:0]         m_eth_src_mac,
   output logic [15:0]         m_eth_type,
   output logic                m_eth_hdr_valid,
   input  logic [47:0]         cfg_local_mac,
   input  logic                cfg_promisc,
   input  logic                cfg_mcast_enable,
   output logic                stat_drop_filter,
   output logic                stat_error_runt
);

   typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [47:0] dest_q, dest_d, src_q, src_d;
   logic [15:0] type_q, type_d;
   logic [47:0] local_q, local_d;
   logic        promisc_q, promisc_d, mcast_q, mcast_d;
   logic [7:0]  tdata_q, tdata_d;
   logic        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
   logic [47:0] eth_dest_q, eth_dest_d, eth_src_q, eth_src_d;
   logic [15:0] eth_type_q, eth_type_d;
   logic        hdr_vld_q, hdr_vld_d, drop_q, drop_d, runt_q, runt_d;

   logic [47:0] dest_next;
   logic        accept;

   // The filter looks at the address including the byte being accepted (byte 5).
   assign dest_next = {dest_q[39:0], s_axis.tdata};
   assign accept    = promisc_q | (dest_next == local_q) | (&dest_next) |
                      (dest_next[40] & mcast_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= HDR;
         idx_q      <= 4'd0;
         dest_q     <= '0;
         src_q      <= '0;
         type_q     <= '0;
         local_q    <= '0;
         promisc_q  <= 1'b0;
         mcast_q    <= 1'b0;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         tuser_q    <= 1'b0;
         eth_dest_q <= '0;
         eth_src_q  <= '0;
         eth_type_q <= '0;
         hdr_vld_q  <= 1'b0;
         drop_q     <= 1'b0;
         runt_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         dest_q     <= dest_d;
         src_q      <= src_d;
         type_q     <= type_d;
         local_q    <= local_d;
         promisc_q  <= promisc_d;
         mcast_q    <= mcast_d;
         tdata_q    <= tdata_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
         tuser_q    <= tuser_d;
         eth_dest_q <= eth_dest_d;
         eth_src_q  <= eth_src_d;
         eth_type_q <= eth_type_d;
         hdr_vld_q  <= hdr_vld_d;
         drop_q     <= drop_d;
         runt_q     <= runt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      dest_d     = dest_q;
      src_d      = src_q;
      type_d     = type_q;
      local_d    = local_q;
      promisc_d  = promisc_q;
      mcast_d    = mcast_q;
      tdata_d    = tdata_q;
      tvalid_d   = 1'b0;
      tlast_d    = 1'b0;
      tuser_d    = 1'b0;
      eth_dest_d = eth_dest_q;
      eth_src_d  = eth_src_q;
      eth_type_d = eth_type_q;
      hdr_vld_d  = 1'b0;
      drop_d     = 1'b0;
      runt_d     = 1'b0;

      if (s_axis.tvalid) begin
         if (s_axis.tlast)
            idx_d = 4'd0;
         else if (idx_q != 4'd14)
            idx_d = idx_q + 4'd1;

         case (state_q)
            HDR: begin
               if (idx_q == 4'd0) begin
                  local_d   = cfg_local_mac;
                  promisc_d = cfg_promisc;
                  mcast_d   = cfg_mcast_enable;
               end
               if (idx_q < 4'd6)
                  dest_d = dest_next;
               else if (idx_q < 4'd12)
                  src_d = {src_q[39:0], s_axis.tdata};
               else
                  type_d = {type_q[7:0], s_axis.tdata};

               if (s_axis.tlast) begin
                  runt_d  = 1'b1;
                  state_d = HDR;
               end else if (idx_q == 4'd5 && !accept) begin
                  state_d = DROP;
               end else if (idx_q == 4'd13) begin
                  hdr_vld_d  = 1'b1;
                  eth_dest_d = dest_q;
                  eth_src_d  = src_q;
                  eth_type_d = {type_q[7:0], s_axis.tdata};
                  state_d    = PAYLOAD;
               end
            end
            PAYLOAD: begin
               tvalid_d = 1'b1;
               tdata_d  = s_axis.tdata;
               tlast_d  = s_axis.tlast;
               tuser_d  = s_axis.tlast & s_axis.tuser;
               if (s_axis.tlast)
                  state_d = HDR;
            end
            DROP: begin
               // A rejected frame that ends inside the header is reported as a runt only.
               if (s_axis.tlast) begin
                  state_d = HDR;
                  if (idx_q <= 4'd13)
                     runt_d = 1'b1;
                  else
                     drop_d = 1'b1;
               end
            end
            default: state_d = HDR;
         endcase
      end
   end

   assign m_axis.tdata     = tdata_q;
   assign m_axis.tvalid    = tvalid_q;
   assign m_axis.tlast     = tlast_q;
   assign m_axis.tuser     = tuser_q;
   assign m_eth_dest_mac   = eth_dest_q;
   assign m_eth_src_mac    = eth_src_q;
   assign m_eth_type       = eth_type_q;
   assign m_eth_hdr_valid  = hdr_vld_q;
   assign stat_drop_filter = drop_q;
   assign stat_error_runt  = runt_q;

endmodule

// File: doc/eth_rx_hdr_filter.md
# eth_rx_hdr_filter

Receive-side stage placed directly downstream of the 10M/100M MII MAC. It consumes the MAC's 8-bit receive AXI stream, which has no backpressure. It extracts the 14-byte Ethernet header into registered fields, applies a destination-address filter, and forwards only the payload bytes of accepted frames. The filter decision completes before any payload byte, so rejected frames are dropped without buffering.

## Interface
Parameters:
- none; header length fixed at 14 bytes, stream width fixed at 8 bits.

Ports:
- clk  in  1  receive clock, same domain as the MAC receive stream.
- rst  in  1  reset; one clock, asynchronous, active-high.
- s_axis_tdata  in  8  receive byte from MAC.
- s_axis_tvalid  in  1  byte valid; no tready exists, so every valid byte is consumed.
- s_axis_tlast  in  1  last byte of frame.
- s_axis_tuser  in  1  bad frame (FCS or PHY error); meaningful only with tlast.
- m_axis_tdata  out  8  payload byte (frame bytes 14 onward).
- m_axis_tvalid  out  1  payload byte valid; no tready.
- m_axis_tlast  out  1  last payload byte.
- m_axis_tuser  out  1  copy of s_axis_tuser on the last byte.
- m_eth_dest_mac  out  48  destination MAC; first received byte in [47:40].
- m_eth_src_mac  out  48  source MAC; first received byte in [47:40].
- m_eth_type  out  16  EtherType; first received byte in [15:8].
- m_eth_hdr_valid  out  1  one-cycle pulse; header fields are valid and held until the next pulse.
- cfg_local_mac  in  48  station address; byte order as m_eth_dest_mac.
- cfg_promisc  in  1  accept all destinations.
- cfg_mcast_enable  in  1  accept group addresses (dest[40]=1).
- stat_drop_filter  out  1  pulse: frame rejected by the filter.
- stat_error_runt  out  1  pulse: tlast arrived at or before header byte 13.

## Operation
- Byte index counter: 4 bits, counts accepted bytes 0..14 and saturates at 14. It clears to 0 after any tlast.
- States: HDR (bytes 0-13), PAYLOAD, DROP.
- HDR: each byte is shifted into the dest, src or type register by index. cfg_* inputs are sampled at byte 0 and held for the frame.
- Filter evaluated on byte 5. A frame is accepted if any of the following holds; otherwise state moves to DROP:
  - cfg_promisc;
  - dest == cfg_local_mac;
  - dest == 48'hFFFF_FFFF_FFFF (broadcast is always accepted);
  - dest[40]=1 and cfg_mcast_enable.
- Byte 13 accepted without tlast, frame accepted -> m_eth_hdr_valid pulses, state moves to PAYLOAD.
- PAYLOAD: every input byte is forwarded. tlast returns the state to HDR.
- DROP: bytes are discarded. On tlast, stat_drop_filter pulses and the state returns to HDR. A rejected frame never raises m_eth_hdr_valid.
- tlast in HDR at index <= 13 (runt) -> stat_error_runt pulses, no hdr_valid, state returns to HDR.
  - This includes a runt already rejected by the filter; such a frame counts as a runt only, with no drop pulse.
- Bad frames (tuser=1) are not dropped. The header is still published; tuser is passed through on m_axis_tlast for downstream discard.
- Gaps (tvalid=0) anywhere are allowed; state and counter hold.

## Timing
- Reset values:
  - all m_axis_* = 0;
  - m_eth_* fields = 0;
  - m_eth_hdr_valid = 0;
  - stat_* = 0;
  - state HDR, index 0.
- Payload latency: exactly 1 cycle from an input byte to m_axis_tvalid. tdata, tlast and tuser are registered together.
- m_eth_hdr_valid is asserted the cycle after byte 13 is accepted. This is at least one cycle before the first m_axis_tvalid of that frame.
- Header fields update on the same edge as the hdr_valid pulse and stay stable through the payload.
- stat_* pulses are asserted the cycle after the terminating tlast byte.
- Reset asserted mid-frame: outputs clear immediately (asynchronous). The next byte after deassertion is treated as byte 0; resynchronisation relies on the MAC being reset alongside.
- Back-to-back frames (tlast followed next cycle by a new byte 0) are supported with zero idle cycles.

## Test plan
- Frame to cfg_local_mac=02:00:00:00:00:01, EtherType 0x0800, 50-byte payload, no gaps:
  - hdr_valid pulses once with correct fields;
  - 50 payload bytes out, 1-cycle delay, tlast on byte 50, tuser=0.
- Dest 02:00:00:00:00:02, cfg_promisc=0:
  - no m_axis_tvalid, no hdr_valid;
  - stat_drop_filter pulses once, one cycle after tlast.
  - Repeat with cfg_promisc=1: frame forwarded.
- Dest FF:FF:FF:FF:FF:FF accepted with promisc=0 and mcast=0. Dest 01:00:5E:00:00:01 is dropped with mcast=0 and accepted with mcast=1.
- 10-byte frame with tlast on byte 9: stat_error_runt pulses, no hdr_valid, no payload. The next 64-byte frame is parsed correctly.
- Accepted frame with tuser=1 on tlast and random tvalid gaps:
  - payload matches input order;
  - m_axis_tuser=1 only on m_axis_tlast.
- Two back-to-back accepted frames, zero idle, then rst asserted mid-payload of a third:
  - two hdr_valid pulses;
  - all outputs 0 during reset;
  - a clean fourth frame is parsed.
